// File: rtl/kb_fifo.sv
// PS/2 keyboard receiver with glitch-filtered clock, frame checks, inter-bit watchdog and a scan-code FIFO.
// Define KB_PREFIX_EN to fold E0/F0 prefixes into ext/rel flags stored with each FIFO entry.
module kb_fifo #(
    parameter int DEPTH   = 16,
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 25000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   ps_clock,
    input  logic                   ps_data,
    input  logic                   rd,
    input  logic                   clr,
    output logic [7:0]             data,
    output logic                   ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   perr,
    output logic                   ext,
    output logic                   rel
);

    // state  | meaning
    // IDLE   | waiting for a start bit (falling edge with data=0)
    // DATA   | shifting in 8 data bits, LSB first
    // PARITY | capturing the odd-parity bit
    // STOP   | checking stop bit and parity, pushing a valid byte
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(FILTER + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [FW-1:0] FLT_LOAD = FW'(FILTER - 1);
    localparam logic [TW-1:0] WD_LOAD  = TW'(TIMEOUT);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
`ifdef KB_PREFIX_EN
    localparam int EW = 10;
`else
    localparam int EW = 8;
`endif

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          filt_clk;
    logic [FW-1:0] flt_cnt;
    logic          fall;

    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] wd_cnt;
    logic          timeout, frame_valid, frame_bad, perr_evt;

    logic          push_req, do_push, do_pop, full, ovf_evt;
    logic [EW-1:0] wdata;
    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [AW:0]   cnt_nxt;
    logic [EW-1:0] head_q, head_nxt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps_clock;
            clk_s2 <= clk_s1;
            dat_s1 <= ps_data;
            dat_s2 <= dat_s1;
        end
    end

    // Filtered clock flips only after FILTER consecutive samples disagree with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            filt_clk <= 1'b1;
            flt_cnt  <= FLT_LOAD;
        end else if (clk_s2 == filt_clk) begin
            flt_cnt <= FLT_LOAD;
        end else if (flt_cnt == '0) begin
            filt_clk <= clk_s2;
            flt_cnt  <= FLT_LOAD;
        end else begin
            flt_cnt <= flt_cnt - FW'(1);
        end
    end

    assign fall        = filt_clk && !clk_s2 && (flt_cnt == '0);
    assign timeout     = (state != IDLE) && !fall && (wd_cnt == '0);
    assign frame_valid = (state == STOP) && fall && dat_s2 && (^shreg ^ par_bit);
    assign frame_bad   = (state == STOP) && fall && !(dat_s2 && (^shreg ^ par_bit));
    assign perr_evt    = frame_bad || timeout;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            wd_cnt  <= WD_LOAD;
        end else begin
            if (fall)
                wd_cnt <= WD_LOAD;
            else if (state != IDLE && wd_cnt != '0)
                wd_cnt <= wd_cnt - TW'(1);

            if (timeout) begin
                state <= IDLE;
            end else if (fall) begin
                case (state)
                    IDLE: begin
                        if (!dat_s2) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg   <= {dat_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= PARITY;
                    end
                    PARITY: begin
                        par_bit <= dat_s2;
                        state   <= STOP;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef KB_PREFIX_EN
    logic ext_pend, rel_pend, is_prefix;

    assign is_prefix = (shreg == 8'hE0) || (shreg == 8'hF0);
    assign push_req  = frame_valid && !is_prefix;
    assign wdata     = {ext_pend, rel_pend, shreg};

    // Prefix latches are consumed by the next data byte, whether or not it fits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ext_pend <= 1'b0;
            rel_pend <= 1'b0;
        end else if (perr_evt) begin
            ext_pend <= 1'b0;
            rel_pend <= 1'b0;
        end else if (frame_valid) begin
            if (shreg == 8'hE0) begin
                ext_pend <= 1'b1;
            end else if (shreg == 8'hF0) begin
                rel_pend <= 1'b1;
            end else begin
                ext_pend <= 1'b0;
                rel_pend <= 1'b0;
            end
        end
    end

    assign ext = head_q[9];
    assign rel = head_q[8];
`else
    assign push_req = frame_valid;
    assign wdata    = shreg;
    assign ext      = 1'b0;
    assign rel      = 1'b0;
`endif

    assign full    = (count == FULL_CNT);
    assign do_pop  = rd && (count != '0);
    assign do_push = push_req && (!full || do_pop);
    assign ovf_evt = push_req && full && !do_pop;
    assign rd_nxt  = do_pop ? rd_ptr + AW'(1) : rd_ptr;

    always_comb begin
        cnt_nxt = count;
        if (do_push && !do_pop)
            cnt_nxt = count + (AW + 1)'(1);
        else if (!do_push && do_pop)
            cnt_nxt = count - (AW + 1)'(1);
    end

    // The new head may be the word being written this cycle, so bypass the RAM then.
    always_comb begin
        head_nxt = mem[rd_nxt];
        if (cnt_nxt == '0)
            head_nxt = '0;
        else if (do_push && rd_nxt == wr_ptr)
            head_nxt = wdata;
    end

    always_ff @(posedge clock) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            head_q   <= '0;
            overflow <= 1'b0;
            perr     <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            rd_ptr   <= rd_nxt;
            count    <= cnt_nxt;
            head_q   <= head_nxt;
            overflow <= (overflow && !clr) || ovf_evt;
            perr     <= (perr && !clr) || perr_evt;
        end
    end

    assign data  = head_q[7:0];
    assign ready = (count != '0);

endmodule
